// File: rtl/mips_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   - default datapath widths
//   - access FSM state encoding (IDLE / WAIT)
//   - EX/MEM control bundle and its bubble (all-zero) value
//   - word-alignment helper used by the optional misalignment trap
package mips_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 32;
  localparam int RADDR_W_DEF = 5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{valid: 1'b0, regwrite: 1'b0, memread: 1'b0,
                                    memwrite: 1'b0, memtoreg: 1'b0};

  // True when a byte address does not sit on a 32-bit word boundary.
  function automatic logic is_misaligned(input logic [1:0] i_lo);
    return (i_lo != 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory access sequencer.
// Tracks one outstanding access (IDLE/WAIT), counts wait cycles for the
// timeout, and generates the request, stall and error signals.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   i_op      : EX/MEM holds a valid load or store
//   i_trap    : current op is rejected (misaligned, trap build only)
//   i_ack     : memory acknowledge
//   o_req     : combinational access request
//   o_stall   : combinational pipeline freeze
//   o_err     : registered one-cycle error pulse (timeout or trap), aligned
//               with the MEM/WB copy of the faulting instruction
module mem_access_fsm
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_op,
  input  logic i_trap,
  input  logic i_ack,
  output logic o_req,
  output logic o_stall,
  output logic o_err
);

  // Wide enough to hold TIMEOUT itself; TIMEOUT = 0 still gets one bit.
  localparam int              CNT_W       = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic            TIMEOUT_EN  = (TIMEOUT > 0);

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_err;
  logic             w_access;
  logic             w_timeout_hit;

  // Request qualification and timeout detection.
  // r_count equals the number of request cycles already spent, so the hit
  // lands after exactly TIMEOUT stall cycles.
  always_comb begin
    w_access      = i_op & ~i_trap;
    w_timeout_hit = TIMEOUT_EN & (r_state == ST_WAIT) & (r_count == TIMEOUT_CNT);
  end

  assign o_req   = w_access;
  assign o_stall = w_access & ~i_ack & ~w_timeout_hit;
  assign o_err   = r_err;

  // State register, wait counter and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      // A real ack beats a coincident timeout: the data is good.
      r_err <= i_trap | (w_timeout_hit & ~i_ack);
      case (r_state)
        ST_IDLE: begin
          if (w_access && !i_ack) begin
            r_state <= ST_WAIT;
            r_count <= CNT_W'(1);
          end else begin
            r_state <= ST_IDLE;
            r_count <= '0;
          end
        end
        ST_WAIT: begin
          if (!w_access || i_ack || w_timeout_hit) begin
            r_state <= ST_IDLE;
            r_count <= '0;
          end else begin
            r_state <= ST_WAIT;
            r_count <= r_count + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data-memory access and MEM/WB register.
// Optional feature macro: MISALIGN_TRAP_EN -- when defined, a load/store whose
// address is not word aligned issues no request and raises mem_err instead of
// silently clearing the low address bits.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   ex_*                     : instruction and control bits from EX
//   dmem_req/we/addr/wdata   : request side of the data-memory port
//   dmem_rdata/ack           : response side of the data-memory port
//   mem_stall                : freeze upstream stages while an access is pending
//   mem_aluout/rd/regwrite   : EX/MEM copy for the forwarding unit
//   wb_data/rd/regwrite      : MEM/WB copy for write-back
//   mem_err                  : one-cycle pulse on timeout or misalignment trap
module mem_stage
  import mips_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid,
  input  logic [DATA_W-1:0]  ex_aluout,
  input  logic [DATA_W-1:0]  ex_store_data,
  input  logic [RADDR_W-1:0] ex_rd,
  input  logic               ex_regwrite,
  input  logic               ex_memread,
  input  logic               ex_memwrite,
  input  logic               ex_memtoreg,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [ADDR_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,
  output logic               mem_stall,
  output logic [DATA_W-1:0]  mem_aluout,
  output logic [RADDR_W-1:0] mem_rd,
  output logic               mem_regwrite,
  output logic [DATA_W-1:0]  wb_data,
  output logic [RADDR_W-1:0] wb_rd,
  output logic               wb_regwrite,
  output logic               mem_err
);

  ctrl_t              r_ctrl;
  logic [DATA_W-1:0]  r_aluout;
  logic [DATA_W-1:0]  r_store_data;
  logic [RADDR_W-1:0] r_rd;
  logic [DATA_W-1:0]  r_wb_data;
  logic [RADDR_W-1:0] r_wb_rd;
  logic               r_wb_regwrite;

  logic               w_op;
  logic               w_trap;
  logic               w_req;
  logic               w_stall;
  logic               w_err;
  logic [DATA_W-1:0]  w_rdata;
  logic [DATA_W-1:0]  w_wb_data;
  logic               w_wb_regwrite;

  // Memory-op decode, trap decision and write-back mux.
  always_comb begin
    w_op = r_ctrl.valid & (r_ctrl.memread | r_ctrl.memwrite);
`ifdef MISALIGN_TRAP_EN
    w_trap = w_op & is_misaligned(r_aluout[1:0]);
`else
    w_trap = 1'b0;
`endif
    // Load data only counts when it answers our own request; a timed-out
    // access returns zero.
    if (w_req && dmem_ack) begin
      w_rdata = dmem_rdata;
    end else begin
      w_rdata = '0;
    end
    if (r_ctrl.memtoreg) begin
      w_wb_data = w_rdata;
    end else begin
      w_wb_data = r_aluout;
    end
    w_wb_regwrite = r_ctrl.regwrite & r_ctrl.valid & ~w_trap;
  end

  mem_access_fsm #(
    .TIMEOUT (TIMEOUT)
  ) u_fsm (
    .clk     (clk),
    .rst     (rst),
    .i_op    (w_op),
    .i_trap  (w_trap),
    .i_ack   (dmem_ack),
    .o_req   (w_req),
    .o_stall (w_stall),
    .o_err   (w_err)
  );

  // EX/MEM register: frozen while stalled, bubble control when EX is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl       <= CTRL_BUBBLE;
      r_aluout     <= '0;
      r_store_data <= '0;
      r_rd         <= '0;
    end else if (!w_stall) begin
      if (ex_valid) begin
        r_ctrl <= '{valid: 1'b1, regwrite: ex_regwrite, memread: ex_memread,
                    memwrite: ex_memwrite, memtoreg: ex_memtoreg};
      end else begin
        r_ctrl <= CTRL_BUBBLE;
      end
      r_aluout     <= ex_aluout;
      r_store_data <= ex_store_data;
      r_rd         <= ex_rd;
    end else begin
      r_ctrl       <= r_ctrl;
      r_aluout     <= r_aluout;
      r_store_data <= r_store_data;
      r_rd         <= r_rd;
    end
  end

  // MEM/WB register: takes the finished instruction, or a bubble while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_data     <= '0;
      r_wb_rd       <= '0;
      r_wb_regwrite <= 1'b0;
    end else if (!w_stall) begin
      r_wb_data     <= w_wb_data;
      r_wb_rd       <= r_rd;
      r_wb_regwrite <= w_wb_regwrite;
    end else begin
      r_wb_data     <= '0;
      r_wb_rd       <= '0;
      r_wb_regwrite <= 1'b0;
    end
  end

  // Memory port; address, data and direction come straight from EX/MEM so
  // they stay stable for the whole access. Write wins when both bits are set.
  assign dmem_req     = w_req;
  assign dmem_we      = w_req & r_ctrl.memwrite;
  assign dmem_addr    = {r_aluout[ADDR_W-1:2], 2'b00};
  assign dmem_wdata   = r_store_data;
  assign mem_stall    = w_stall;

  assign mem_aluout   = r_aluout;
  assign mem_rd       = r_rd;
  assign mem_regwrite = r_ctrl.regwrite & r_ctrl.valid;

  assign wb_data      = r_wb_data;
  assign wb_rd        = r_wb_rd;
  assign wb_regwrite  = r_wb_regwrite;
  assign mem_err      = w_err;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: an instruction-level model of the MEM
// stage (one instruction in flight, elapsed request cycles, word memory)
// predicts every output each cycle; directed cases pin the model with literals.
module tb_mem_stage;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = 5;
  localparam int TO = 4;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
  logic [DW-1:0] ex_aluout, ex_store_data;
  logic [RW-1:0] ex_rd;
  logic          dmem_req, dmem_we, dmem_ack;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata, dmem_rdata;
  logic          mem_stall, mem_regwrite, wb_regwrite, mem_err;
  logic [DW-1:0] mem_aluout, wb_data;
  logic [RW-1:0] mem_rd, wb_rd;

  always #5 clk = ~clk;

  mem_stage #(.DATA_W(DW), .ADDR_W(AW), .RADDR_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_aluout(ex_aluout), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mem_stall(mem_stall), .mem_aluout(mem_aluout), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .mem_err(mem_err)
  );

  typedef struct {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw, mr, mw, mtr;
    int          lat;   // cycles until the bench memory acks this access
  } instr_t;

  // Model state
  instr_t      m_cur;
  int          m_waited;
  logic [31:0] e_wb_data;
  logic [4:0]  e_wb_rd;
  logic        e_wb_rw, e_err;
  logic [31:0] mem [0:63];

  int n_pass, n_total;
  int stall_cnt;
  logic        snap_req;
  logic [31:0] snap_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic instr_t mk(input logic [31:0] alu, input logic [31:0] sd,
                                input logic [4:0] rd, input logic rw,
                                input logic mr, input logic mw, input int lat);
    instr_t t;
    t.valid = 1'b1; t.alu = alu; t.sd = sd; t.rd = rd;
    t.rw = rw; t.mr = mr; t.mw = mw; t.mtr = mr; t.lat = lat;
    return t;
  endfunction

  function automatic instr_t bub();
    instr_t t;
    t = mk($urandom, $urandom, 5'($urandom_range(0, 31)), 1'b0, 1'b0, 1'b0, 0);
    t.valid = 1'b0;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    int k;
    logic [31:0] a;
    k = $urandom_range(0, 9);
    a = $urandom;
    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    t = mk(a, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
           (k >= 3 && k <= 5) || k == 9, (k >= 6 && k <= 8) || k == 9,
           ($urandom_range(0, 7) == 0) ? 7 : $urandom_range(0, 3));
    t.valid = (k != 0);
    return t;
  endfunction

  task automatic model_reset();
    m_cur = mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 0);
    m_cur.valid = 1'b0;
    m_waited = 0;
    e_wb_data = 32'h0; e_wb_rd = 5'd0; e_wb_rw = 1'b0; e_err = 1'b0;
  endtask

  task automatic drive_idle();
    ex_valid = 1'b0; ex_aluout = '0; ex_store_data = '0; ex_rd = '0;
    ex_regwrite = 1'b0; ex_memread = 1'b0; ex_memwrite = 1'b0; ex_memtoreg = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
  endtask

  // One clock: drive nx at EX, act as the memory, check every output, advance model.
  task automatic step(input instr_t nx);
    logic op, trap, acc, ack_v, tohit, stall_e;
    logic [31:0] rdata_v;
    int idx;
    @(negedge clk);
    op      = m_cur.valid & (m_cur.mr | m_cur.mw);
    trap    = op & TRAP_EN & (m_cur.alu[1:0] != 2'b00);
    acc     = op & ~trap;
    idx     = int'(m_cur.alu[7:2]);
    ack_v   = acc ? (m_waited == m_cur.lat) : ($urandom_range(0, 3) == 0);
    rdata_v = (acc && ack_v && !m_cur.mw) ? mem[idx] : $urandom;
    tohit   = acc & (TO > 0) & (m_waited == TO);
    stall_e = acc & ~ack_v & ~tohit;
    ex_valid = nx.valid; ex_aluout = nx.alu; ex_store_data = nx.sd; ex_rd = nx.rd;
    ex_regwrite = nx.rw; ex_memread = nx.mr; ex_memwrite = nx.mw; ex_memtoreg = nx.mtr;
    dmem_ack = ack_v; dmem_rdata = rdata_v;
    #1;
    chk("dmem_req", dmem_req, acc);
    chk("mem_stall", mem_stall, stall_e);
    if (acc) begin
      chk("dmem_addr", dmem_addr, m_cur.alu & 32'hFFFF_FFFC);
      chk("dmem_wdata", dmem_wdata, m_cur.sd);
      chk("dmem_we", dmem_we, m_cur.mw);
    end
    chk("mem_aluout", mem_aluout, m_cur.alu);
    chk("mem_rd", mem_rd, m_cur.rd);
    chk("mem_regwrite", mem_regwrite, m_cur.valid & m_cur.rw);
    chk("wb_data", wb_data, e_wb_data);
    chk("wb_rd", wb_rd, e_wb_rd);
    chk("wb_regwrite", wb_regwrite, e_wb_rw);
    chk("mem_err", mem_err, e_err);
    snap_req = dmem_req; snap_addr = dmem_addr;
    if (mem_stall) stall_cnt++;
    @(posedge clk);
    if (acc && ack_v && m_cur.mw) mem[idx] = m_cur.sd;
    e_err = trap | (acc & ~ack_v & tohit);
    if (stall_e) begin
      e_wb_data = 32'h0; e_wb_rd = 5'd0; e_wb_rw = 1'b0;
      m_waited++;
    end else begin
      e_wb_data = m_cur.mtr ? ((acc && ack_v) ? rdata_v : 32'h0) : m_cur.alu;
      e_wb_rd   = m_cur.rd;
      e_wb_rw   = m_cur.valid & m_cur.rw & ~trap;
      m_waited  = 0;
      m_cur     = nx;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0; n_total = 0; stall_cnt = 0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    rst = 1'b1;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst dmem_req", dmem_req, 1'b0);
    chk("rst mem_stall", mem_stall, 1'b0);
    chk("rst wb_data", wb_data, 32'h0);
    chk("rst wb_regwrite", wb_regwrite, 1'b0);
    chk("rst mem_aluout", mem_aluout, 32'h0);
    chk("rst mem_err", mem_err, 1'b0);
    @(negedge clk) rst = 1'b0;

    // 1: plain ALU op
    step(mk(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 0));
    step(bub());
    #1;
    chk("t1 wb_data", wb_data, 32'h1234);
    chk("t1 wb_rd", wb_rd, 5'd5);
    chk("t1 wb_regwrite", wb_regwrite, 1'b1);

    // 2: zero-wait load
    mem[16] = 32'hDEAD_BEEF;
    step(mk(32'h40, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 0));
    stall_cnt = 0;
    step(bub());
    #1;
    chk("t2 wb_data", wb_data, 32'hDEAD_BEEF);
    chk("t2 stall cycles", stall_cnt, 0);

    // 3: store acked after 3 wait cycles
    step(mk(32'h80, 32'hA5A5_A5A5, 5'd2, 1'b0, 1'b0, 1'b1, 3));
    stall_cnt = 0;
    repeat (5) step(bub());
    #1;
    chk("t3 stall cycles", stall_cnt, 3);
    chk("t3 stored word", mem[32], 32'hA5A5_A5A5);

    // 4: load that never gets an ack
    step(mk(32'h10, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 100));
    stall_cnt = 0;
    repeat (5) step(bub());
    #1;
    chk("t4 stall cycles", stall_cnt, 4);
    chk("t4 wb_data", wb_data, 32'h0);
    chk("t4 wb_regwrite", wb_regwrite, 1'b1);
    chk("t4 mem_err", mem_err, 1'b1);
    step(bub());

    // 5: reset in the middle of a wait
    step(mk(32'h20, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 100));
    repeat (2) step(bub());
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5 dmem_req", dmem_req, 1'b0);
    chk("t5 mem_stall", mem_stall, 1'b0);
    chk("t5 dmem_addr", dmem_addr, 32'h0);
    chk("t5 mem_aluout", mem_aluout, 32'h0);
    chk("t5 mem_rd", mem_rd, 5'd0);
    chk("t5 wb_rd", wb_rd, 5'd0);
    @(posedge clk);
    drive_idle();
    model_reset();
    @(negedge clk) rst = 1'b0;
    step(mk(32'h55, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 0));
    step(bub());
    #1;
    chk("t5 post wb_data", wb_data, 32'h55);
    chk("t5 post wb_regwrite", wb_regwrite, 1'b1);

    // 6: misaligned load from 0x42
    step(mk(32'h42, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 0));
    step(bub());
`ifdef MISALIGN_TRAP_EN
    chk("t6 dmem_req", snap_req, 1'b0);
    #1;
    chk("t6 mem_err", mem_err, 1'b1);
    chk("t6 wb_regwrite", wb_regwrite, 1'b0);
`else
    chk("t6 dmem_addr", snap_addr, 32'h40);
    #1;
    chk("t6 mem_err", mem_err, 1'b0);
`endif

    // Randomised traffic
    repeat (1500) step(rand_instr());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
